// File: rtl/uart_tx_fifo_if.sv
// Handshake bundle between cmd_parser, the TX byte FIFO and uart_tx.
// master = producer/consumer side, slave = the FIFO itself.
interface uart_tx_fifo_if #(
  parameter int AW = 4
);
  logic [7:0]  wr_data;
  logic        wr_en;
  logic        full;
  logic        empty;
  logic [AW:0] level;
  logic        overflow;
  logic        clr_ovf;
  logic        flush;
  logic [7:0]  tx_data;
  logic        tx_start;
  logic        tx_ready;

  modport master (
    output wr_data, wr_en, clr_ovf, flush, tx_ready,
    input  full, empty, level, overflow, tx_data, tx_start
  );

  modport slave (
    input  wr_data, wr_en, clr_ovf, flush, tx_ready,
    output full, empty, level, overflow, tx_data, tx_start
  );
endinterface

// File: rtl/uart_tx_fifo.sv
// Byte FIFO that buffers parser output and drains it into uart_tx
// one byte per start/ready handshake, with level and sticky overflow reporting.
module uart_tx_fifo #(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic          clk,
  input  logic          rst,
  uart_tx_fifo_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE,
    START,
    WAIT_LOW,
    WAIT_HIGH
  } state_t;

  localparam logic [AW:0] FULL_LEVEL = (AW+1)'(DEPTH);

  state_t          state;
  logic [7:0]      mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [AW:0]     level;
  logic            full;
  logic            empty;
  logic            wr_acc;
  logic            pop;
  logic            overflow;
  logic [7:0]      tx_data;
  logic            tx_start;

  assign full   = (level == FULL_LEVEL);
  assign empty  = (level == '0);
  assign wr_acc = bus.wr_en && !full;
  assign pop    = (state == IDLE) && !empty && bus.tx_ready && !bus.flush;

  assign bus.full     = full;
  assign bus.empty    = empty;
  assign bus.level    = level;
  assign bus.overflow = overflow;
  assign bus.tx_data  = tx_data;
  assign bus.tx_start = tx_start;

  // Storage has no reset; a stale slot is never read because level guards pops.
  always_ff @(posedge clk) begin
    if (wr_acc) begin
      mem[wr_ptr] <= bus.wr_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else if (bus.flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (wr_acc) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (wr_acc && !pop) begin
        level <= level + 1'b1;
      end else if (!wr_acc && pop) begin
        level <= level - 1'b1;
      end
    end
  end

  // A dropped write wins over a same-cycle clear so the event is never lost.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow <= 1'b0;
    end else if (bus.wr_en && full) begin
      overflow <= 1'b1;
    end else if (bus.clr_ovf) begin
      overflow <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      tx_data  <= 8'h00;
      tx_start <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          tx_start <= 1'b0;
          if (pop) begin
            tx_data  <= mem[rd_ptr];
            tx_start <= 1'b1;
            state    <= START;
          end
        end
        START: begin
          tx_start <= 1'b0;
          state    <= WAIT_LOW;
        end
        // uart_tx may take several cycles to drop ready after the start pulse.
        WAIT_LOW: begin
          tx_start <= 1'b0;
          if (!bus.tx_ready) begin
            state <= WAIT_HIGH;
          end
        end
        WAIT_HIGH: begin
          tx_start <= 1'b0;
          if (bus.tx_ready) begin
            state <= IDLE;
          end
        end
        default: begin
          tx_start <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
Byte buffer and drain controller between cmd_parser (producer of tx_data/new_tx_data) and uart_tx (consumer of data/start, producer of ready).
- Absorbs bursts of response/echo bytes from the parser.
- Feeds uart_tx one byte at a time using its start/ready handshake, so no byte is dropped while the serial line is busy.
- Reports level, full/empty and a sticky overflow flag, which can be routed to the debug LEDs.

Parameters:
DEPTH, 16, FIFO entries; must be a power of two, 2..256
AW, 4, pointer width; must equal log2(DEPTH)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous reset, active high
wr_data  in  8  byte from cmd_parser
wr_en  in  1  write strobe, one byte per cycle it is high (driven by new_tx_data)
full  out  1  FIFO holds DEPTH entries
empty  out  1  FIFO holds 0 entries
level  out  AW+1  current occupancy, 0..DEPTH
overflow  out  1  sticky: a write was attempted while full
clr_ovf  in  1  synchronous clear of overflow
flush  in  1  synchronous discard of all stored bytes
tx_data  out  8  byte presented to uart_tx data
tx_start  out  1  one-cycle start pulse to uart_tx
tx_ready  in  1  uart_tx ready (high = transmitter idle)

Behaviour:
- Reset: rst is asynchronous and active high. While rst=1:
  - rd_ptr, wr_ptr and level are 0.
  - empty=1, full=0, overflow=0.
  - tx_start=0 and tx_data=8'h00.
  - FSM is in IDLE.
  - Storage contents are don't-care.
- Reset mid-operation: a byte already handed to uart_tx is not recalled. All buffered bytes are lost.
- Storage: DEPTH x 8 array. Pointers are AW bits and wrap modulo DEPTH. level is a separate AW+1-bit counter.
- Flag decode: full = (level==DEPTH); empty = (level==0). Both are combinational from the level register.
- Write:
  - Accepted on a rising edge where wr_en=1 and full=0 (full sampled before the edge).
  - An accepted write stores wr_data at wr_ptr and increments wr_ptr.
- Write while full: the byte is discarded, pointers are unchanged, and overflow is set to 1.
- Pop: performed only by the FSM (see IDLE). Reads the array at rd_ptr into tx_data and increments rd_ptr.
- Level update: level_next = level + (write accepted) - (pop). A write and a pop in the same cycle leave level unchanged.
  - A write while full is rejected even if a pop occurs in the same cycle.
- flush:
  - Sets rd_ptr=wr_ptr=0 and level=0.
  - Overrides a same-cycle write and pop.
  - Does not affect the FSM, tx_data or overflow.
- overflow: set has priority over a same-cycle clr_ovf.
- FSM states and transitions:
  - IDLE: if empty=0, tx_ready=1 and flush=0, pop into tx_data and go to START. Otherwise stay.
  - START: tx_start=1 for exactly this cycle; tx_data stable. Go to WAIT_LOW.
  - WAIT_LOW: stay until tx_ready=0, then go to WAIT_HIGH. This covers uart_tx deasserting ready one or more cycles after start.
  - WAIT_HIGH: stay until tx_ready=1, then go to IDLE.
- tx_data is held constant from the pop until the next pop. tx_start is registered and is high only in START.
- Latency: a write accepted at edge N into an empty FIFO with tx_ready=1 gives pop at edge N+1 and tx_start high in cycle N+1..N+2. This is 2 cycles from write to start.
- Back-to-back bytes: the next pop occurs on the first edge after returning to IDLE, so there is 1 idle cycle of FSM overhead per byte.
- Throughput: one byte per uart_tx frame; the FIFO never stalls the serial line beyond that overhead.

Test Plan:
- Reset and idle: rst=1 then 0, tx_ready=1, no writes -> empty=1, level=0, tx_start stays 0, tx_data=00.
- Single byte, uart model drops ready 1 cycle after start and holds it low 10 cycles: write 8'h41 -> tx_start pulse 2 cycles later with tx_data=41. Exactly one pulse; level returns to 0.
- Burst of 5 bytes (01..05) in consecutive cycles while the uart model is busy -> level peaks at 5. Bytes reach uart_tx in order 01,02,03,04,05, one start per ready rise.
- Fill and overflow with tx_ready=0: 17 writes of 00..10 -> full=1 after the 16th, overflow=1 after the 17th. Later drain yields 00..0F only; clr_ovf clears overflow.
- Pointer wrap: 40 bytes streamed with a continuously draining uart model -> all 40 received in order, level never exceeds DEPTH.
- Flush and async reset: with 6 bytes queued and one in flight, assert flush -> level=0, in-flight byte completes, no further starts. Then assert rst in WAIT_LOW -> all outputs return to reset values immediately, without waiting for a clock edge.
